// File: rtl/pci_conf_cyc_addr_xlat_if.sv
// Request/result handshake bundle for the PCI configuration-cycle address translator.
interface pci_conf_cyc_addr_xlat_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [7:0]  sec_bus_num;
    logic [7:0]  sub_bus_num;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic        out_type1;
    logic        out_range_err;
    logic        out_unclaimed;

    modport master (
        output in_valid, in_addr, sec_bus_num, sub_bus_num, out_ready,
        input  in_ready, out_valid, out_addr, out_type1, out_range_err, out_unclaimed
    );

    modport slave (
        input  in_valid, in_addr, sec_bus_num, sub_bus_num, out_ready,
        output in_ready, out_valid, out_addr, out_type1, out_range_err, out_unclaimed
    );
endinterface

// File: rtl/pci_conf_cyc_addr_xlat.sv
// Two-stage PCI configuration address translator: classifies Type 0/Type 1 requests,
// drives the IDSEL line for local devices and counts range/unclaimed errors.
module pci_conf_cyc_addr_xlat #(
    parameter int unsigned IDSEL_BASE    = 11,
    parameter int unsigned NUM_DEV       = 21,
    parameter bit          TYPE1_CONVERT = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        flush_in,
    input  logic        err_cnt_clr_in,
    output logic [15:0] err_cnt_out,
    pci_conf_cyc_addr_xlat_if.slave xlat
);

    typedef struct packed {
        logic [31:0] addr;
        logic        type1;
        logic        range_err;
        logic        unclaimed;
    } res_t;

    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    res_t        s1_q, s1_d;
    res_t        s2_q, s2_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        s2_adv;
    logic        in_ready_int;
    logic        accept;
    res_t        cls;

    logic [4:0]  dev;
    logic [7:0]  bus_num;
    logic        is_type0;
    logic        dev_ok;
    logic [31:0] idsel_bits;

    // Classification of the incoming request.
    always_comb begin
        dev        = xlat.in_addr[15:11];
        bus_num    = xlat.in_addr[23:16];
        dev_ok     = 32'(dev) < NUM_DEV;
        is_type0   = !xlat.in_addr[0] ||
                     (TYPE1_CONVERT && (bus_num == xlat.sec_bus_num));
        idsel_bits = dev_ok ? (32'd1 << (IDSEL_BASE + 32'(dev))) : 32'd0;

        cls = '0;
        if (is_type0) begin
            cls.addr      = idsel_bits | {21'd0, xlat.in_addr[10:2], 2'b00};
            cls.type1     = 1'b0;
            cls.range_err = !dev_ok;
        end else begin
            cls.addr      = xlat.in_addr;
            cls.type1     = 1'b1;
            // bus == sec was converted above, so <= here only catches buses below sec.
            cls.unclaimed = TYPE1_CONVERT &&
                            ((bus_num <= xlat.sec_bus_num) || (bus_num > xlat.sub_bus_num));
        end
    end

    always_comb begin
        s2_adv       = !s2_valid_q || xlat.out_ready;
        in_ready_int = !s1_valid_q || s2_adv;
        accept       = xlat.in_valid && in_ready_int;

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready_int) begin
            s1_valid_d = xlat.in_valid;
        end
        if (accept) begin
            s1_d = cls;
        end

        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = s1_q;
            end
        end

        if (flush_in) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (err_cnt_clr_in) begin
            err_cnt_d = 16'd0;
        end else if (s2_valid_q && xlat.out_ready && (s2_q.range_err || s2_q.unclaimed) &&
                     (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            err_cnt_q  <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Valids are already cleared in reset; gate in_ready so nothing is offered meanwhile.
    assign xlat.in_ready      = !reset_in && in_ready_int;
    assign xlat.out_valid     = s2_valid_q;
    assign xlat.out_addr      = s2_q.addr;
    assign xlat.out_type1     = s2_q.type1;
    assign xlat.out_range_err = s2_q.range_err;
    assign xlat.out_unclaimed = s2_q.unclaimed;
    assign err_cnt_out        = err_cnt_q;

endmodule

// File: tb/tb_pci_conf_cyc_addr_xlat.sv
// Self-checking bench: directed vectors with literal expectations plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_pci_conf_cyc_addr_xlat;

    localparam int unsigned IdselBase = 11;
    localparam int unsigned NumDev    = 21;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        flush_in;
    logic        err_cnt_clr_in;
    logic [15:0] err_cnt_out;

    pci_conf_cyc_addr_xlat_if xif ();

    pci_conf_cyc_addr_xlat #(
        .IDSEL_BASE    (IdselBase),
        .NUM_DEV       (NumDev),
        .TYPE1_CONVERT (1'b1)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .flush_in       (flush_in),
        .err_cnt_clr_in (err_cnt_clr_in),
        .err_cnt_out    (err_cnt_out),
        .xlat           (xif)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned acc;
        logic [31:0] addr;
        logic        t1;
        logic        re;
        logic        un;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    logic [15:0] m_cnt = 16'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference translation from the addressing rules (TYPE1_CONVERT = 1).
    function automatic exp_t xlat_ref(input logic [31:0] a, input logic [7:0] sec,
                                      input logic [7:0] sub);
        exp_t        r;
        int unsigned dev;
        logic [7:0]  bus;
        dev   = 32'(a[15:11]);
        bus   = a[23:16];
        r.acc = 0;
        r.re  = 1'b0;
        r.un  = 1'b0;
        if (a[0] == 1'b0 || bus == sec) begin
            r.t1   = 1'b0;
            r.addr = a & 32'h0000_07FC;
            if (dev < NumDev) r.addr = r.addr | (32'd1 << (IdselBase + dev));
            else r.re = 1'b1;
        end else begin
            r.t1   = 1'b1;
            r.addr = a;
            r.un   = (bus <= sec) || (bus > sub);
        end
        return r;
    endfunction

    // Per-cycle compare against the model, then advance the model by this cycle's events.
    always @(negedge clk_in) begin : compare
        logic ev, er, hs;
        exp_t h, r;
        cyc++;
        if (reset_in) begin
            chk1("rst_out_valid", xif.out_valid, 1'b0);
            chk1("rst_in_ready", xif.in_ready, 1'b0);
            chk("rst_out_addr", xif.out_addr, 32'd0);
            chk1("rst_type1", xif.out_type1, 1'b0);
            chk1("rst_range_err", xif.out_range_err, 1'b0);
            chk1("rst_unclaimed", xif.out_unclaimed, 1'b0);
            chk("rst_err_cnt", 32'(err_cnt_out), 32'd0);
            q.delete();
            m_cnt = 16'd0;
        end else begin
            er = (q.size() < 2) || xif.out_ready;
            ev = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk1("in_ready", xif.in_ready, er);
            chk1("out_valid", xif.out_valid, ev);
            chk("err_cnt", 32'(err_cnt_out), 32'(m_cnt));
            if (ev) begin
                chk("out_addr", xif.out_addr, q[0].addr);
                chk1("out_type1", xif.out_type1, q[0].t1);
                chk1("out_range_err", xif.out_range_err, q[0].re);
                chk1("out_unclaimed", xif.out_unclaimed, q[0].un);
            end
            hs = ev && xif.out_ready;
            if (hs) begin
                h = q.pop_front();
                if ((h.re || h.un) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (err_cnt_clr_in) m_cnt = 16'd0;
            if (flush_in) begin
                q.delete();
            end else if (xif.in_valid && er) begin
                r     = xlat_ref(xif.in_addr, xif.sec_bus_num, xif.sub_bus_num);
                r.acc = cyc;
                q.push_back(r);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Single request into an empty pipeline with out_ready=1; checks 2-cycle latency.
    task automatic send_check(input logic [31:0] a, input logic [31:0] ea, input logic et1,
                              input logic ere, input logic eun);
        xif.in_valid = 1'b1;
        xif.in_addr  = a;
        tick();
        xif.in_valid = 1'b0;
        @(negedge clk_in);
        chk1("lat_early_valid", xif.out_valid, 1'b0);
        tick();
        @(negedge clk_in);
        chk1("lat_valid", xif.out_valid, 1'b1);
        chk("lat_addr", xif.out_addr, ea);
        chk1("lat_type1", xif.out_type1, et1);
        chk1("lat_range_err", xif.out_range_err, ere);
        chk1("lat_unclaimed", xif.out_unclaimed, eun);
    endtask

    initial begin : stim
        logic [31:0] rnd;
        logic [7:0]  sec, sub, bus;
        exp_t        p;

        xif.in_valid    = 1'b0;
        xif.in_addr     = 32'd0;
        xif.sec_bus_num = 8'd5;
        xif.sub_bus_num = 8'd9;
        xif.out_ready   = 1'b1;
        flush_in        = 1'b0;
        err_cnt_clr_in  = 1'b0;
        #1 reset_in = 1'b1;

        // Pin the reference model with hand-computed values.
        p = xlat_ref(32'h0000_1004, 8'd5, 8'd9);
        chk("model_t0", p.addr, 32'h0000_2004);
        p = xlat_ref(32'h0005_1909, 8'd5, 8'd9);
        chk("model_conv", p.addr, 32'h0000_4108);
        p = xlat_ref(32'h000A_1909, 8'd5, 8'd9);
        chk1("model_uncl", p.un, 1'b1);

        repeat (3) tick();
        @(negedge clk_in);
        chk1("reset_in_ready", xif.in_ready, 1'b0);
        tick();
        reset_in = 1'b0;
        @(negedge clk_in);
        chk1("post_reset_ready", xif.in_ready, 1'b1);
        tick();

        send_check(32'h0000_1004, 32'h0000_2004, 1'b0, 1'b0, 1'b0);
        tick();
        send_check(32'h0000_A800, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        tick();
        @(negedge clk_in);
        chk("cnt_after_range", 32'(err_cnt_out), 32'd1);
        tick();
        send_check(32'h0005_1909, 32'h0000_4108, 1'b0, 1'b0, 1'b0);
        tick();
        send_check(32'h0007_1909, 32'h0007_1909, 1'b1, 1'b0, 1'b0);
        tick();
        send_check(32'h000A_1909, 32'h000A_1909, 1'b1, 1'b0, 1'b1);
        tick();
        @(negedge clk_in);
        chk("cnt_after_uncl", 32'(err_cnt_out), 32'd2);
        tick();
        send_check(32'h0005_F801, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        tick();

        // Backpressure: two held, third stalls, then drained with no gaps.
        xif.out_ready = 1'b0;
        xif.in_valid  = 1'b1;
        xif.in_addr   = 32'h0000_0000;
        tick();
        xif.in_addr = 32'h0000_0800;
        tick();
        xif.in_addr = 32'h0000_1000;
        repeat (2) begin
            @(negedge clk_in);
            chk1("bp_in_ready", xif.in_ready, 1'b0);
            chk1("bp_valid", xif.out_valid, 1'b1);
            chk("bp_hold_addr", xif.out_addr, 32'h0000_0800);
            tick();
        end
        xif.out_ready = 1'b1;
        @(negedge clk_in);
        chk("bp_out0", xif.out_addr, 32'h0000_0800);
        tick();
        xif.in_valid = 1'b0;
        @(negedge clk_in);
        chk1("bp_valid1", xif.out_valid, 1'b1);
        chk("bp_out1", xif.out_addr, 32'h0000_1000);
        tick();
        @(negedge clk_in);
        chk1("bp_valid2", xif.out_valid, 1'b1);
        chk("bp_out2", xif.out_addr, 32'h0000_2000);
        tick();

        // Reset with both stages full.
        xif.out_ready = 1'b0;
        xif.in_valid  = 1'b1;
        xif.in_addr   = 32'h0000_A800;
        tick();
        xif.in_addr = 32'h0000_1004;
        tick();
        xif.in_valid = 1'b0;
        @(negedge clk_in);
        chk1("full_valid", xif.out_valid, 1'b1);
        tick();
        reset_in = 1'b1;
        @(negedge clk_in);
        chk1("midrst_valid", xif.out_valid, 1'b0);
        chk("midrst_cnt", 32'(err_cnt_out), 32'd0);
        tick();
        reset_in      = 1'b0;
        xif.out_ready = 1'b1;
        send_check(32'h0000_1004, 32'h0000_2004, 1'b0, 1'b0, 1'b0);
        tick();

        // Flush discards held data and the request accepted in the flush cycle.
        xif.out_ready = 1'b0;
        xif.in_valid  = 1'b1;
        xif.in_addr   = 32'h0000_0000;
        tick();
        xif.in_addr = 32'h0000_0800;
        flush_in    = 1'b1;
        tick();
        flush_in     = 1'b0;
        xif.in_valid = 1'b0;
        @(negedge clk_in);
        chk1("flush_valid", xif.out_valid, 1'b0);
        chk1("flush_ready", xif.in_ready, 1'b1);
        tick();
        xif.out_ready = 1'b1;
        @(negedge clk_in);
        chk1("flush_valid2", xif.out_valid, 1'b0);
        tick();

        // Saturation of the error counter.
        err_cnt_clr_in = 1'b1;
        tick();
        err_cnt_clr_in = 1'b0;
        xif.in_valid   = 1'b1;
        xif.in_addr    = 32'h0000_A800;
        repeat (65535) tick();
        xif.in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk_in);
        chk("cnt_sat", 32'(err_cnt_out), 32'h0000_FFFF);
        tick();
        send_check(32'h0000_A800, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        tick();
        @(negedge clk_in);
        chk("cnt_sat_hold", 32'(err_cnt_out), 32'h0000_FFFF);
        tick();
        xif.in_valid = 1'b1;
        tick();
        xif.in_valid = 1'b0;
        tick();
        err_cnt_clr_in = 1'b1;
        @(negedge clk_in);
        chk1("clr_hs_valid", xif.out_valid, 1'b1);
        tick();
        err_cnt_clr_in = 1'b0;
        @(negedge clk_in);
        chk("cnt_clr_wins", 32'(err_cnt_out), 32'd0);
        tick();

        // Randomized traffic checked by the compare process.
        repeat (3000) begin
            sec = 8'($urandom_range(0, 250));
            sub = sec + 8'($urandom_range(0, 5));
            case ($urandom_range(0, 5))
                0: bus = sec;
                1: bus = sec - 8'd1;
                2: bus = sec + 8'd1;
                3: bus = sub;
                4: bus = sub + 8'd1;
                default: bus = 8'($urandom_range(0, 255));
            endcase
            rnd             = $urandom();
            rnd[23:16]      = bus;
            rnd[0]          = 1'($urandom_range(0, 1));
            xif.in_addr     = rnd;
            xif.sec_bus_num = sec;
            xif.sub_bus_num = sub;
            xif.in_valid    = $urandom_range(0, 3) != 0;
            xif.out_ready   = $urandom_range(0, 3) != 0;
            flush_in        = $urandom_range(0, 63) == 0;
            err_cnt_clr_in  = $urandom_range(0, 63) == 0;
            reset_in        = $urandom_range(0, 255) == 0;
            tick();
        end
        reset_in       = 1'b0;
        flush_in       = 1'b0;
        err_cnt_clr_in = 1'b0;
        xif.in_valid   = 1'b0;
        xif.out_ready  = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_conf_cyc_addr_xlat.md
PCI_CONF_CYC_ADDR_XLAT -- requirements
Module: pci_conf_cyc_addr_xlat

Interface
REQ-001 SHALL have parameter IDSEL_BASE, default 11: AD bit that carries the IDSEL of device 0.
REQ-002 SHALL have parameter NUM_DEV, default 21: number of IDSEL lines; IDSEL_BASE >= 11 and IDSEL_BASE+NUM_DEV <= 32 are legal, other values are unsupported.
REQ-003 SHALL have parameter TYPE1_CONVERT, default 1: 1 converts Type 1 cycles to the secondary bus into Type 0; 0 passes every Type 1 cycle through unchanged.
REQ-004 clk_in  input  1  single clock; all state on the rising edge.
REQ-005 reset_in  input  1  asynchronous, active-high reset.
REQ-006 flush_in  input  1  synchronous clear of both pipeline stages.
REQ-007 in_valid / in_ready  input / output  1 / 1  request handshake.
REQ-008 in_addr  input  32  configuration address; bit 0 = 1 means Type 1, bit 0 = 0 means Type 0.
REQ-009 sec_bus_num / sub_bus_num  input  8 / 8  secondary / subordinate bus numbers, sampled at acceptance.
REQ-010 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-011 out_addr  output  32  translated AD value.
REQ-012 out_type1  output  1  1 = forwarded as a Type 1 cycle.
REQ-013 out_range_err  output  1  Type 0 device number >= NUM_DEV.
REQ-014 out_unclaimed  output  1  Type 1 bus number outside [sec_bus_num, sub_bus_num].
REQ-015 err_cnt_clr_in / err_cnt_out  input / output  1 / 16  error counter clear / value.

Function
REQ-016 SHALL be a 2-stage pipeline: S1 (classify) and S2 (output register); latency is exactly 2 cycles from acceptance (in_valid & in_ready) to out_valid when not stalled.
REQ-017 SHALL implement the handshakes as: S2 advances when !out_valid | out_ready; S1 advances when S2 can accept; in_ready = !S1_valid | S1 advances; throughput 1 per cycle; no loss or duplication; order preserved.
REQ-018 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-019 SHALL take dev = in_addr[15:11] and bus = in_addr[23:16].
REQ-020 SHALL treat a request as Type 0 when in_addr[0]=0, or when in_addr[0]=1, TYPE1_CONVERT=1 and bus == sec_bus_num.
REQ-021 SHALL build a Type 0 result as: out_addr[10:2] = in_addr[10:2]; out_addr[1:0] = 00; out_addr[31:11] all zero except bit IDSEL_BASE+dev = 1 when dev < NUM_DEV; out_type1=0.
REQ-022 SHALL set out_range_err=1 and leave no IDSEL bit set when a Type 0 result has dev >= NUM_DEV.
REQ-023 SHALL pass every other Type 1 request through with out_addr = in_addr and out_type1=1.
REQ-024 SHALL set out_unclaimed=1 on a passed-through Type 1 only when TYPE1_CONVERT=1 and bus <= sec_bus_num or bus > sub_bus_num; the address is still passed through.
REQ-025 SHALL raise only flags that belong to the result type, and SHALL never raise both flags together.
REQ-026 SHALL increment err_cnt_out by 1 on each output handshake (out_valid & out_ready) that carries out_range_err or out_unclaimed, saturating at 0xFFFF.
REQ-027 SHALL clear err_cnt_out to 0 on err_cnt_clr_in; when err_cnt_clr_in and an increment fall in the same cycle, the result is 0.
REQ-028 SHALL, on flush_in, clear both stage valids on the next edge and discard any input accepted in that same cycle; err_cnt_out is not affected by flush_in.

Reset
REQ-029 SHALL drive, while reset_in is high, out_valid=0, out_addr=0, out_type1=0, out_range_err=0, out_unclaimed=0, err_cnt_out=0 and in_ready=0, and SHALL clear all internal valids.
REQ-030 SHALL, when reset_in rises mid-operation, drop in-flight requests with no output handshake; in_ready=1 on the first edge after reset_in deasserts.

Verification
REQ-031 Type 0, in_addr=0x0000_1004, out_ready=1 -> two cycles later out_valid=1, out_addr=0x0000_2004, out_type1=0, no flags.
REQ-032 Type 0, in_addr=0x0000_A800 (dev 21, defaults) -> out_addr=0x0000_0000, out_range_err=1, err_cnt_out=1 after the handshake.
REQ-033 sec=5, sub=9, in_addr=0x0005_1909 -> out_addr=0x0000_4108, out_type1=0; in_addr=0x0007_1909 -> passed through, out_type1=1, no flag; in_addr=0x000A_1909 -> passed through, out_unclaimed=1.
REQ-034 out_ready=0, three back-to-back requests -> two held, in_ready=0, third stalls; out_ready=1 -> all three delivered in order with no gaps.
REQ-035 reset_in pulsed with both stages full -> out_valid=0 at once, err_cnt_out=0, no output handshake; the next request gives normal 2-cycle latency.
REQ-036 err_cnt preloaded to 0xFFFF via 65535 errors, then one more error -> 0xFFFF; err_cnt_clr_in together with an error -> 0.
